// File: rtl/ik_swift_hps_master_0_p2b_encoder.sv
// ---------------------------------------------------------------------------
// ik_swift_hps_master_0_p2b_encoder
//
// Avalon-ST packets-to-bytes encoder for the FPGA -> host return path.
// Each accepted 8-bit channelised beat is serialised into an escaped byte
// stream using the reserved bytes 0x7A (SOP), 0x7B (EOP), 0x7C (channel)
// and 0x7D (escape). Reserved payload or channel bytes are sent as
// 0x7D followed by the byte XOR 0x20. One beat expands to 1..7 bytes.
// A single beat is buffered, so in_ready backpressures the source.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both high. The source holds data stable while valid is high and ready
// is low. in_ready may depend combinationally on out_ready; out_valid and
// out_data depend only on registered state.
//
// Parameters
//   CHANNEL_WIDTH  : width of in_channel (1..8). The channel is
//                    zero-extended to 8 bits before it is encoded.
//   ENCODE_CHANNEL : 1 = emit channel sequences; 0 = never emit them.
//
// Ports
//   clk              : clock; all logic is rising-edge.
//   reset            : synchronous, active-high reset.
//   in_ready         : beat accepted when in_valid & in_ready.
//   in_valid         : input beat valid.
//   in_data          : payload byte.
//   in_channel       : channel of the beat.
//   in_startofpacket : first beat of the packet.
//   in_endofpacket   : last beat of the packet.
//   out_ready        : sink accepts out_data when out_valid & out_ready.
//   out_valid        : out_data valid.
//   out_data         : encoded byte.
// ---------------------------------------------------------------------------
module ik_swift_hps_master_0_p2b_encoder #(
    parameter int CHANNEL_WIDTH  = 8,
    parameter bit ENCODE_CHANNEL = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data
);

    localparam logic [7:0] SOP_BYTE  = 8'h7A;
    localparam logic [7:0] EOP_BYTE  = 8'h7B;
    localparam logic [7:0] CHAN_BYTE = 8'h7C;
    localparam logic [7:0] ESC_BYTE  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    // IDLE doubles as "beat buffer empty"; every other state presents a byte.
    typedef enum logic [2:0] {
        IDLE,
        CHAN_CHAR,
        CHAN_ESC,
        CHAN_VAL,
        SOP_CHAR,
        EOP_CHAR,
        DATA_ESC,
        DATA_VAL
    } state_t;

    state_t      state;
    state_t      next_state;
    state_t      first_state;

    logic [7:0]  buf_data;
    logic [7:0]  buf_chan;
    logic        buf_sop;
    logic        buf_eop;
    logic [7:0]  last_channel;
    logic        chan_sent;

    logic [7:0]  chan_ext;
    logic        emit_chan;
    logic        accept;
    logic        advance;
    logic [7:0]  byte_out;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_BYTE) && (b <= ESC_BYTE);
    endfunction

    // Data element: escape first when the payload is a reserved byte.
    function automatic state_t data_first(input logic [7:0] d);
        return is_special(d) ? DATA_ESC : DATA_VAL;
    endfunction

    // Next element after the SOP marker slot.
    function automatic state_t after_sop(input logic eop, input logic [7:0] d);
        return eop ? EOP_CHAR : data_first(d);
    endfunction

    // Next element after the channel sequence slot.
    function automatic state_t after_chan(input logic sop, input logic eop,
                                          input logic [7:0] d);
        return sop ? SOP_CHAR : after_sop(eop, d);
    endfunction

    always_comb begin
        chan_ext                    = '0;
        chan_ext[CHANNEL_WIDTH-1:0] = in_channel;
    end

    // A channel sequence opens every packet and follows any channel change.
    assign emit_chan = ENCODE_CHANNEL &&
                       (in_startofpacket || !chan_sent || (chan_ext != last_channel));

    // Buffer frees up either when empty or when its final byte leaves now,
    // which lets back-to-back beats stream without a bubble.
    assign in_ready  = !reset && ((state == IDLE) || ((state == DATA_VAL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign advance   = (state != IDLE) && out_ready;

    assign first_state = emit_chan ? CHAN_CHAR
                                   : after_chan(in_startofpacket, in_endofpacket, in_data);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = first_state;
            end
            CHAN_CHAR: begin
                if (advance) next_state = is_special(buf_chan) ? CHAN_ESC : CHAN_VAL;
            end
            CHAN_ESC: begin
                if (advance) next_state = CHAN_VAL;
            end
            CHAN_VAL: begin
                if (advance) next_state = after_chan(buf_sop, buf_eop, buf_data);
            end
            SOP_CHAR: begin
                if (advance) next_state = after_sop(buf_eop, buf_data);
            end
            EOP_CHAR: begin
                if (advance) next_state = data_first(buf_data);
            end
            DATA_ESC: begin
                if (advance) next_state = DATA_VAL;
            end
            DATA_VAL: begin
                if (advance) next_state = accept ? first_state : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output byte is a pure decode of state and the buffered beat.
    always_comb begin
        byte_out = 8'h00;
        case (state)
            IDLE:      byte_out = 8'h00;
            CHAN_CHAR: byte_out = CHAN_BYTE;
            CHAN_ESC:  byte_out = ESC_BYTE;
            CHAN_VAL:  byte_out = is_special(buf_chan) ? (buf_chan ^ ESC_XOR) : buf_chan;
            SOP_CHAR:  byte_out = SOP_BYTE;
            EOP_CHAR:  byte_out = EOP_BYTE;
            DATA_ESC:  byte_out = ESC_BYTE;
            DATA_VAL:  byte_out = is_special(buf_data) ? (buf_data ^ ESC_XOR) : buf_data;
            default:   byte_out = 8'h00;
        endcase
    end

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    assign out_valid = !reset && (state != IDLE);
    assign out_data  = reset ? 8'h00 : byte_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            buf_data     <= 8'h00;
            buf_chan     <= 8'h00;
            buf_sop      <= 1'b0;
            buf_eop      <= 1'b0;
            last_channel <= 8'h00;
            chan_sent    <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                buf_data <= in_data;
                buf_chan <= chan_ext;
                buf_sop  <= in_startofpacket;
                buf_eop  <= in_endofpacket;
                if (emit_chan) begin
                    last_channel <= chan_ext;
                    chan_sent    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ik_swift_hps_master_0_p2b_encoder.sv
module tb_ik_swift_hps_master_0_p2b_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  int   cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- DUT 1: channel encoding on ----------------
  logic       in_ready, in_valid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [7:0] in_data = 8'h00, in_channel = 8'h00;
  logic       out_ready = 1'b1, out_valid;
  logic [7:0] out_data;

  ik_swift_hps_master_0_p2b_encoder #(.CHANNEL_WIDTH(8), .ENCODE_CHANNEL(1'b1)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(sop),
    .in_endofpacket(eop), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data));

  // ---------------- DUT 2: channel encoding off ----------------
  logic       in_ready2, in_valid2 = 1'b0, sop2 = 1'b0, eop2 = 1'b0;
  logic [7:0] in_data2 = 8'h00;
  logic [3:0] in_channel2 = 4'h0;
  logic       out_ready2 = 1'b1, out_valid2;
  logic [7:0] out_data2;

  ik_swift_hps_master_0_p2b_encoder #(.CHANNEL_WIDTH(4), .ENCODE_CHANNEL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_ready(in_ready2), .in_valid(in_valid2),
    .in_data(in_data2), .in_channel(in_channel2), .in_startofpacket(sop2),
    .in_endofpacket(eop2), .out_ready(out_ready2), .out_valid(out_valid2),
    .out_data(out_data2));

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];
  logic [7:0] beat_q[$];
  int         byte_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         byte_cnt = 0;
  int         count_7c = 0;
  logic [7:0] m_last_ch = 8'h00;
  bit         m_chan_sent = 1'b0;
  int         rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_esc(input logic [7:0] b);
    if (b >= 8'h7A && b <= 8'h7D) begin
      beat_q.push_back(8'h7D);
      beat_q.push_back(b ^ 8'h20);
    end else begin
      beat_q.push_back(b);
    end
  endfunction

  function automatic void model_beat(input logic [7:0] d, input logic [7:0] ch,
                                     input bit s, input bit e, input bit enc);
    beat_q.delete();
    if (enc && (s || !m_chan_sent || ch != m_last_ch)) begin
      beat_q.push_back(8'h7C);
      push_esc(ch);
      m_last_ch   = ch;
      m_chan_sent = 1'b1;
    end
    if (s) beat_q.push_back(8'h7A);
    if (e) beat_q.push_back(8'h7B);
    push_esc(d);
  endfunction

  // ---------------- out_ready drivers ----------------
  bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int pidx = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        out_ready  = pat[pidx];
        pidx       = (pidx + 1) % 6;
        out_ready2 = 1'b1;
      end
      2: begin
        out_ready  = 1'($urandom_range(0, 1));
        out_ready2 = 1'($urandom_range(0, 1));
      end
      default: begin
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
      end
    endcase
  end

  // ---------------- monitors ----------------
  bit         stalled = 1'b0;
  logic [7:0] stall_data = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none (t=%0t)", out_data, $time);
        end else begin
          check("byte", 32'(out_data), 32'(exp_q.pop_front()));
        end
        byte_cnt++;
        byte_cyc_q.push_back(cycle);
      end
      stalled    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid2 && out_ready2) begin
      if (out_data2 == 8'h7C) count_7c++;
      if (exp_q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte2 actual=%0h required=none (t=%0t)", out_data2, $time);
      end else begin
        check("byte2", 32'(out_data2), 32'(exp_q2.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] ch,
                      input bit s, input bit e, output int waits);
    bit ok;
    if (sel) begin
      in_data2 = d; in_channel2 = ch[3:0]; sop2 = s; eop2 = e; in_valid2 = 1'b1;
    end else begin
      in_data = d; in_channel = ch; sop = s; eop = e; in_valid = 1'b1;
    end
    waits = 0;
    ok    = 1'b0;
    while (!ok && waits <= 200) begin
      @(negedge clk);
      if (sel ? in_ready2 : in_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=%0d required=<=200 (t=%0t)", waits, $time);
    end else begin
      model_beat(d, ch, s, e, !sel);
      foreach (beat_q[i]) begin
        if (sel) exp_q2.push_back(beat_q[i]);
        else     exp_q.push_back(beat_q[i]);
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_bound", 32'(n < 1000), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(0, 3) == 0) return 8'(8'h7A + $urandom_range(0, 3));
    return 8'($urandom_range(0, 255));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int base;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_in_ready2", 32'(in_ready2), 32'd0);
    check("rst_out_valid2", 32'(out_valid2), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single-beat packet: 5 bytes on consecutive cycles, in_ready only at the last.
    byte_cyc_q.delete();
    send(0, 8'h41, 8'h00, 1, 1, w);
    check("t1_accept_wait", 32'(w), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_in_ready", 32'(in_ready), 32'(i == 4));
    end
    @(posedge clk);
    #1;
    drain();
    check("t1_len", 32'(byte_cyc_q.size()), 32'd5);
    if (byte_cyc_q.size() == 5)
      check("t1_consecutive", 32'(byte_cyc_q[4] - byte_cyc_q[0]), 32'd4);

    // Three-beat packet with escaped data, then the same under backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      rdy_mode = pass;
      send(0, 8'h11, 8'h05, 1, 0, w);
      send(0, 8'h7D, 8'h05, 0, 0, w);
      send(0, 8'h22, 8'h05, 0, 1, w);
      drain();
    end
    rdy_mode = 0;

    // Reserved channel and data: 7-byte beat, then a mid-packet channel switch.
    send(0, 8'h7C, 8'h7B, 1, 1, w);
    send(0, 8'h33, 8'h06, 0, 0, w);
    drain();

    // Back-to-back plain beats stream at one beat per clock.
    send(0, 8'h10, 8'h05, 1, 0, w);
    for (int i = 0; i < 4; i++) begin
      send(0, 8'(8'h20 + i), 8'h05, 0, 0, w);
      if (i > 0) check("stream_wait", 32'(w), 32'd0);
    end
    drain();

    // Reset after two bytes: remaining bytes are dropped, then a fresh beat.
    base = byte_cnt;
    send(0, 8'h41, 8'h00, 1, 1, w);
    n = 0;
    while (byte_cnt < base + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("rst_mid_bound", 32'(n < 50), 32'd1);
    #1 reset = 1'b1;
    exp_q.delete();
    m_chan_sent = 1'b0;
    m_last_ch   = 8'h00;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    byte_cyc_q.delete();
    send(0, 8'h41, 8'h00, 1, 1, w);
    drain();
    check("post_rst_len", 32'(byte_cyc_q.size()), 32'd5);

    // Channel encoding disabled: channel is ignored entirely.
    send(1, 8'h41, 8'h09, 1, 0, w);
    send(1, 8'h42, 8'h03, 0, 1, w);
    drain();

    // Randomised traffic with random backpressure on both instances.
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] ch;
      case ($urandom_range(0, 3))
        0: ch = 8'h05;
        1: ch = 8'(8'h7A + $urandom_range(0, 3));
        2: ch = 8'h00;
        default: ch = 8'($urandom_range(0, 255));
      endcase
      send(i % 3 == 2, rand_byte(), ch, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, w);
    end
    drain();
    rdy_mode = 0;
    drain();

    check("no_chan_byte_dut2", 32'(count_7c), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ik_swift_hps_master_0_p2b_encoder.md
Name: ik_swift_hps_master_0_p2b_encoder

Overview:
- Avalon-ST packets-to-bytes encoder for the host-master link return path (FPGA -> host).
- Accepts 8-bit channelised packet beats and serialises them into an escaped byte stream: 0x7A=SOP, 0x7B=EOP, 0x7C=channel, 0x7D=escape.
- It is the transmit-side counterpart of the bytes-to-packets decoder and channel adapter on the receive path.
- One beat expands to 1-7 output bytes, so the block buffers a single beat and applies backpressure.

Parameters:
- CHANNEL_WIDTH, 8, width of in_channel (1..8); zero-extended to 8 bits when encoded.
- ENCODE_CHANNEL, 1, 1 = emit channel sequences; 0 = never emit 0x7C sequences and ignore in_channel.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_ready  output  1  beat accepted on clk when in_valid & in_ready.
- in_valid  input  1  input beat valid.
- in_data  input  8  payload byte.
- in_channel  input  CHANNEL_WIDTH  channel of beat.
- in_startofpacket  input  1  first beat of packet.
- in_endofpacket  input  1  last beat of packet.
- out_ready  input  1  sink accepts out_data when out_valid & out_ready.
- out_valid  output  1  out_data valid.
- out_data  output  8  encoded byte.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0x00, in_ready=0 while reset is high.
  - State IDLE, beat buffer empty, chan_sent=0, last_channel=0.
- Reset mid-operation: the buffered beat and any partially sent sequence are discarded, with no completion bytes.
- Capture: in_ready = buffer empty OR (the final byte of the current beat is being accepted this cycle).
  - in_ready may depend combinationally on out_ready; there is no other input-to-output combinational path.
  - On accept, latch data, channel, SOP and EOP, then decide the byte sequence.
- Byte order per beat (each element present only if applicable):
  1. Channel sequence: present when ENCODE_CHANNEL=1 and (SOP, or chan_sent=0, or channel != last_channel).
     - Emit 0x7C, then the channel byte.
     - If the channel byte is in 0x7A..0x7D, emit 0x7D, then channel^0x20.
  2. 0x7A if SOP.
  3. 0x7B if EOP.
  4. Data byte; if in 0x7A..0x7D, emit 0x7D, then data^0x20.
- Beat length:
  - Minimum 1 byte (mid-packet, no escape, no channel change).
  - Maximum 7 bytes (escaped channel + SOP + EOP + escaped data).
- Channel tracking: on accept of a beat that emits a channel sequence, last_channel <= channel and chan_sent <= 1.
- FSM states: IDLE, CHAN_CHAR, CHAN_ESC, CHAN_VAL, SOP_CHAR, EOP_CHAR, DATA_ESC, DATA_VAL.
  - On accept, go to the first applicable state.
  - Advance only on out_valid & out_ready, to the next applicable state.
  - CHAN_ESC precedes CHAN_VAL only for a special channel byte; DATA_ESC precedes DATA_VAL only for a special data byte.
  - From DATA_VAL with a beat accepted the same cycle: go directly to that beat's first state, giving zero bubble.
  - Otherwise go to IDLE.
- Outputs:
  - out_valid=1 in every state except IDLE.
  - out_data is decoded from state plus registered beat only.
  - Both are stable while out_valid & !out_ready (Avalon-ST rule).
- Throughput: 1 byte/clk with out_ready held high; back-to-back plain mid-packet beats give 1 beat/clk.
- No packet-integrity checks: SOP without a prior EOP, or EOP without SOP, is encoded as given.
- in_valid is ignored when in_ready=0.

Test Plan:
- ENCODE_CHANNEL=1, out_ready=1, after reset, beat {ch=0, data=0x41, SOP, EOP} -> bytes 7C 00 7A 7B 41 on 5 consecutive cycles; in_ready low until the 0x41 cycle.
- Packet on ch=0x05, data 0x11 (SOP), 0x7D, 0x22 (EOP) -> 7C 05 7A 11 7D 5D 7B 22; no channel re-emission on beats 2-3.
- Packet on ch=0x7B, one beat {data=0x7C, SOP, EOP} -> 7C 7D 5B 7A 7B 7D 5C (7 bytes); a mid-packet beat switching to ch=0x06 with data 0x33 -> 7C 06 33.
- Backpressure: out_ready pattern 1,0,0,1,0,1... during test 2 -> identical byte sequence; out_data unchanged while stalled; no input beat lost or duplicated.
- Reset asserted for 1 cycle after 2 bytes of test 1 -> out_valid=0 the next cycle; a following beat {ch=0, data=0x41, SOP, EOP} re-emits the full 7C 00 7A 7B 41.
- ENCODE_CHANNEL=0, beats {0x41, SOP}, {0x42, EOP} -> 7A 41 7B 42; 0x7C never emitted; in_channel ignored.
